// File: rtl/dot_accum.sv
// Streaming dot-product accumulator: carry-save accumulation of product terms, one resolving add per result.
// Optional build macro DOT_ACCUM_SIGNED_EN: sign-extend two's-complement terms instead of zero-extending.
module dot_accum #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ACC_W  = 20
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_data
);

  localparam int unsigned EXT_W = ACC_W - DATA_W;

  typedef enum logic [1:0] {
    ACCUM   = 2'd0,
    RESOLVE = 2'd1,
    DONE    = 2'd2
  } state_t;

  state_t             state, state_n;
  logic [ACC_W-1:0]   sum_r, car_r;
  logic [ACC_W-1:0]   sum_n, car_n, out_data_n;
  logic               out_valid_n, in_ready_n;
  logic [ACC_W-1:0]   term, car_sh;

  // Term extension to accumulator width and carry vector weighted by 2 (MSB drops, mod 2^ACC_W)
  always_comb begin
`ifdef DOT_ACCUM_SIGNED_EN
    term = {{EXT_W{in_data[DATA_W-1]}}, in_data};
`else
    term = {{EXT_W{1'b0}}, in_data};
`endif
    car_sh = {car_r[ACC_W-2:0], 1'b0};
  end

  // Next-state and next-register values
  always_comb begin
    state_n     = state;
    sum_n       = sum_r;
    car_n       = car_r;
    out_data_n  = out_data;
    out_valid_n = out_valid;
    in_ready_n  = in_ready;
    unique case (state)
      ACCUM: begin
        if (in_valid) begin
          sum_n = sum_r ^ car_sh ^ term;
          car_n = (sum_r & car_sh) | (sum_r & term) | (car_sh & term);
          if (in_last) begin
            state_n    = RESOLVE;
            in_ready_n = 1'b0;
          end
        end
      end
      RESOLVE: begin
        out_data_n  = sum_r + car_sh;
        out_valid_n = 1'b1;
        state_n     = DONE;
      end
      DONE: begin
        if (out_ready) begin
          out_valid_n = 1'b0;
          sum_n       = '0;
          car_n       = '0;
          state_n     = ACCUM;
          in_ready_n  = 1'b1;
        end
      end
      default: begin
        state_n     = ACCUM;
        sum_n       = '0;
        car_n       = '0;
        out_valid_n = 1'b0;
        in_ready_n  = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ACCUM;
      sum_r     <= '0;
      car_r     <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      state     <= state_n;
      sum_r     <= sum_n;
      car_r     <= car_n;
      out_data  <= out_data_n;
      out_valid <= out_valid_n;
      in_ready  <= in_ready_n;
    end
  end

endmodule

// File: tb/tb_dot_accum.sv
// Scoreboard bench for dot_accum: driver pushes expected sums, monitor pops on each output handshake.
module tb_dot_accum;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned ACC_W  = 20;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [DATA_W-1:0] in_data = '0;
  logic              in_last = 1'b0;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic [ACC_W-1:0]  out_data;

  logic              hold_ready = 1'b1;
  logic              rand_ready = 1'b0;
  logic [ACC_W-1:0]  exp_q[$];
  int                checks = 0;
  int                errors = 0;

  always #5 clk = ~clk;

  dot_accum #(.DATA_W(DATA_W), .ACC_W(ACC_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: a term's integer value under the build's signedness
  function automatic int term_value(input logic [DATA_W-1:0] d);
`ifdef DOT_ACCUM_SIGNED_EN
    return int'($signed(d));
`else
    return int'(d);
`endif
  endfunction

  // Sole owner of out_ready: either random backpressure or the level requested by the sequence
  initial begin
    forever begin
      @(posedge clk);
      #1;
      out_ready = rand_ready ? ($urandom_range(0, 3) != 0) : hold_ready;
    end
  end

  // Monitor: every output handshake must match the oldest expected result
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result: got 0x%0h expected none", out_data);
      end else begin
        check("result", 32'(out_data), 32'(exp_q.pop_front()));
      end
    end
  end

  // Drive a vector starting at posedge+2; returns at posedge+2 after the final transfer
  task automatic send_vector(input logic [DATA_W-1:0] terms[$], input int bubble_pct, input bit close);
    int   sum = 0;
    int   w;
    logic acc;
    foreach (terms[i]) begin
      while ($urandom_range(0, 99) < bubble_pct) begin
        in_valid = 1'b0;
        in_data  = DATA_W'($urandom);
        in_last  = 1'($urandom);
        @(posedge clk);
        #2;
      end
      in_valid = 1'b1;
      in_data  = terms[i];
      in_last  = close && (i == terms.size() - 1);
      w = 0;
      do begin
        @(negedge clk);
        acc = in_ready;
        @(posedge clk);
        #2;
        w++;
      end while (!acc && w < 100);
      if (!acc) begin
        checks++;
        errors++;
        $display("FAIL accept_timeout: got in_ready=0 expected 1 within 100 cycles");
      end
      sum += term_value(terms[i]);
    end
    if (close) exp_q.push_back(ACC_W'(sum));
    in_valid = 1'b0;
    in_data  = DATA_W'($urandom);
    in_last  = 1'($urandom);
  endtask

  task automatic drain(input string name);
    int w = 0;
    while (exp_q.size() != 0 && w < 300) begin
      @(posedge clk);
      w++;
    end
    #2;
    check(name, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_in_ready", 32'(in_ready), 32'd1);
    check("reset_out_data", 32'(out_data), 32'd0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    logic [DATA_W-1:0] v[$];
    int w;

    @(posedge clk);
    #2;
    apply_reset();

    // Single term, then 4 and 17 maximal terms (carry drop at 2^20)
    v = {16'h1234};
    send_vector(v, 0, 1'b1);
    v = {};
    for (int i = 0; i < 4; i++) v.push_back(16'hFFFF);
    send_vector(v, 0, 1'b1);
    v = {};
    for (int i = 0; i < 17; i++) v.push_back(16'hFFFF);
    send_vector(v, 0, 1'b1);
    drain("drain_directed");

    // Stall in DONE: result and in_ready must hold
    hold_ready = 1'b0;
    @(posedge clk);
    #2;
    v = {16'h0100, 16'h0200};
    send_vector(v, 0, 1'b1);
    w = 0;
    do begin
      @(negedge clk);
      w++;
    end while (!out_valid && w < 20);
    check("stall_valid_seen", 32'(out_valid), 32'd1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_out_data", 32'(out_data), 32'h00300);
      check("stall_out_valid", 32'(out_valid), 32'd1);
      check("stall_in_ready", 32'(in_ready), 32'd0);
    end
    @(posedge clk);
    #2;
    hold_ready = 1'b1;
    v = {16'h0001, 16'h0002};
    send_vector(v, 0, 1'b1);
    drain("drain_stall");

    // Bubbled 8-term vector, then reset mid-vector and a fresh 1-term vector
    v = {};
    for (int i = 0; i < 8; i++) v.push_back(DATA_W'($urandom));
    send_vector(v, 40, 1'b1);
    drain("drain_bubbled");
    v = {16'h0011, 16'h0022, 16'h0033};
    send_vector(v, 0, 1'b0);
    apply_reset();
    v = {16'h0005};
    send_vector(v, 0, 1'b1);
    drain("drain_after_reset");

    // Reset while a result is pending in DONE
    hold_ready = 1'b0;
    @(posedge clk);
    #2;
    v = {16'h0007, 16'h0009};
    send_vector(v, 0, 1'b1);
    repeat (3) @(posedge clk);
    #2;
    void'(exp_q.pop_back());
    hold_ready = 1'b1;
    apply_reset();
    v = {16'h0004};
    send_vector(v, 0, 1'b1);
    drain("drain_done_reset");

    // Extension-sensitive pair
    v = {16'hFFFF, 16'h0002};
    send_vector(v, 0, 1'b1);
    drain("drain_ext");

    // Random vectors with bubbles and random backpressure
    rand_ready = 1'b1;
    for (int n = 0; n < 25; n++) begin
      v = {};
      for (int i = 0; i < int'($urandom_range(1, 12)); i++) v.push_back(DATA_W'($urandom));
      send_vector(v, 30, 1'b1);
    end
    drain("drain_random");
    rand_ready = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
